// File: rtl/spi_slave_ctrl_pkg.sv
// spi_slave_ctrl_pkg: shared FSM states and command/header constants for the SPI slave
package spi_slave_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, CMD, PAYLOAD, DISCARD} state_t;
    localparam logic [7:0] CMD_SPI_OFF = 8'h0C;
    localparam logic [7:0] CMD_SOFT_RST = 8'h0D;
    localparam logic [7:0] CMD_SPI_ON = 8'h0E;
    localparam logic [1:0] HDR_PARAM = 2'b01;
    localparam logic [1:0] HDR_ACT = 2'b10;
    localparam logic [1:0] HDR_INST = 2'b11;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with rise/fall detect for one asynchronous bit
module spi_sync_edge #(
    parameter int STAGES = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic prev;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            chain <= STAGES'({chain, d});
            prev <= chain[STAGES-1];
        end
    end
    assign q = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: mode-0 SPI slave with command decode, payload receive and byte readback
module spi_slave_ctrl
    import spi_slave_ctrl_pkg::*;
#(
    parameter int WIDTH_SPI_WORD = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic spi_clk,
    input  logic MOSI,
    input  logic chip_select_n,
    output logic MISO,
    input  logic [WIDTH_SPI_WORD-1:0] tx_data,
    output logic tx_req,
    output logic [WIDTH_SPI_WORD-1:0] rx_data,
    output logic rx_valid,
    output logic [1:0] rx_target,
    output logic rx_first,
    output logic spi_en,
    output logic soft_reset,
    output logic frame_active
);
    localparam int W = WIDTH_SPI_WORD;
    localparam int CW = $clog2(W);
    state_t state, state_n;
    logic sck_rise, sck_fall, mosi_q, mosi_rise, mosi_fall, cs_q, cs_rise, cs_fall;
    logic unused_edges;
    logic [CW-1:0] bit_cnt;
    logic [W-2:0] rx_shift;
    logic [W-1:0] rx_word, tx_shift;
    logic [1:0] hdr, hdr_q;
    logic first_pend, tx_load;
    logic cs_start, sck_ok, byte_done, cmd_done, pay_done;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .reset_n(reset_n), .d(spi_clk), .q(), .rise(sck_rise), .fall(sck_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .reset_n(reset_n), .d(MOSI), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .reset_n(reset_n), .d(chip_select_n), .q(cs_q), .rise(cs_rise), .fall(cs_fall));

    assign unused_edges = ^{sck_fall, mosi_rise, mosi_fall, cs_q};
    assign frame_active = state != IDLE;
    assign MISO = frame_active & tx_shift[W-1];
    assign rx_word = {rx_shift, mosi_q};

    // chip-select rise outranks any spi_clk rise seen in the same clk
    always_comb begin
        hdr = rx_word[W-1 -: 2];
        cs_start = cs_fall && state == IDLE;
        sck_ok = sck_rise && frame_active && !cs_rise;
        byte_done = sck_ok && bit_cnt == CW'(W-1);
        cmd_done = byte_done && state == CMD;
        pay_done = byte_done && state == PAYLOAD;
        state_n = cs_rise ? IDLE :
                  cs_start ? CMD :
                  cmd_done ? (hdr == 2'b00 ? DISCARD : PAYLOAD) : state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            rx_data <= '0;
            rx_target <= '0;
            hdr_q <= '0;
            first_pend <= 1'b0;
            rx_valid <= 1'b0;
            rx_first <= 1'b0;
            tx_req <= 1'b0;
            tx_load <= 1'b0;
            spi_en <= 1'b0;
            soft_reset <= 1'b0;
        end else begin
            soft_reset <= cmd_done && rx_word == W'(CMD_SOFT_RST);
            rx_valid <= pay_done;
            rx_first <= pay_done && first_pend;
            tx_req <= cs_start || byte_done;
            tx_load <= tx_req;
            if (cs_rise) bit_cnt <= '0;
            else if (sck_ok) bit_cnt <= bit_cnt + 1'b1;
            if (sck_ok) rx_shift <= {rx_shift[W-3:0], mosi_q};
            // the completing rise leaves the shifter for the freshly requested byte
            if (tx_load) tx_shift <= tx_data;
            else if (sck_ok && !byte_done) tx_shift <= {tx_shift[W-2:0], 1'b0};
            if (cmd_done && rx_word == W'(CMD_SPI_OFF)) spi_en <= 1'b0;
            else if (cmd_done && rx_word == W'(CMD_SPI_ON)) spi_en <= 1'b1;
            if (cmd_done && hdr != 2'b00) begin
                hdr_q <= hdr;
                first_pend <= 1'b1;
            end else if (pay_done) first_pend <= 1'b0;
            if (pay_done) begin
                rx_data <= rx_word;
                rx_target <= hdr_q;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: directed scenarios for spi_slave_ctrl at clk 10 ns, spi half-period 65 ns
module tb_spi_slave_ctrl;
    import spi_slave_ctrl_pkg::*;
    logic clk = 1'b0;
    logic reset_n, spi_clk, MOSI, chip_select_n, MISO, tx_req, rx_valid, rx_first;
    logic spi_en, soft_reset, frame_active;
    logic [7:0] tx_data, rx_data;
    logic [1:0] rx_target;
    int errors = 0, checks = 0;
    int nv = 0, nsr = 0, tx_cnt = 0, tx_base = 0;
    logic [7:0] v_data[64];
    logic v_first[64];
    logic [1:0] v_tgt[64];
    logic [7:0] tx_tbl[4];
    logic [7:0] rd[3];

    spi_slave_ctrl dut (
        .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk), .MOSI(MOSI),
        .chip_select_n(chip_select_n), .MISO(MISO), .tx_data(tx_data), .tx_req(tx_req),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_target(rx_target), .rx_first(rx_first),
        .spi_en(spi_en), .soft_reset(soft_reset), .frame_active(frame_active));

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        if (rx_valid) begin
            if (nv < 64) begin
                v_data[nv] = rx_data;
                v_first[nv] = rx_first;
                v_tgt[nv] = rx_target;
            end
            nv++;
        end
        if (soft_reset) nsr++;
    end

    initial begin
        tx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_req) begin
                tx_data = (tx_cnt - tx_base < 4) ? tx_tbl[tx_cnt - tx_base] : 8'h00;
                tx_cnt++;
            end
        end
    end

    task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < n; i++) begin
            MOSI = mo[7-i];
            #65;
            mi[7-i] = MISO;
            spi_clk = 1'b1;
            #65;
            spi_clk = 1'b0;
        end
    endtask

    task automatic frame_start();
        tx_base = tx_cnt;
        chip_select_n = 1'b0;
        #130;
    endtask

    task automatic frame_stop();
        #65;
        chip_select_n = 1'b1;
        MOSI = 1'b0;
        #200;
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, input int n);
        logic [7:0] bs[3];
        bs[0] = b0; bs[1] = b1; bs[2] = b2;
        frame_start();
        for (int i = 0; i < n; i++) spi_bits(bs[i], 8, rd[i]);
        frame_stop();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        spi_clk = 1'b0;
        MOSI = 1'b0;
        chip_select_n = 1'b1;
        for (int i = 0; i < 4; i++) tx_tbl[i] = 8'h00;
        #23;
        checks++; if (spi_en !== 1'b0) begin errors++; $display("FAIL reset_spi_en got %b want 0", spi_en); end
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL reset_frame_active got %b want 0", frame_active); end
        reset_n = 1'b1;
        #50;
        checks++; if ({rx_valid, rx_first, tx_req, soft_reset, MISO} !== 5'b0) begin errors++; $display("FAIL reset_strobes got %b want 00000", {rx_valid, rx_first, tx_req, soft_reset, MISO}); end
        checks++; if (rx_data !== 8'h00 || rx_target !== 2'b00) begin errors++; $display("FAIL reset_rx got %h/%b want 00/00", rx_data, rx_target); end
    endtask

    task automatic test_enable();
        int b;
        b = nv;
        frame_start();
        checks++; if (frame_active !== 1'b1) begin errors++; $display("FAIL frame_active_open got %b want 1", frame_active); end
        spi_bits(8'h0E, 8, rd[0]);
        frame_stop();
        checks++; if (spi_en !== 1'b1) begin errors++; $display("FAIL en_on got %b want 1", spi_en); end
        checks++; if (nv - b !== 0) begin errors++; $display("FAIL en_no_valid got %0d want 0", nv - b); end
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL frame_active_closed got %b want 0", frame_active); end
        send_frame(8'h0C, 8'h00, 8'h00, 1);
        checks++; if (spi_en !== 1'b0) begin errors++; $display("FAIL en_off got %b want 0", spi_en); end
    endtask

    task automatic test_soft_reset();
        int b;
        send_frame(8'h0E, 8'h00, 8'h00, 1);
        b = nsr;
        send_frame(8'h0D, 8'h00, 8'h00, 1);
        checks++; if (nsr - b !== 1) begin errors++; $display("FAIL soft_reset_pulses got %0d want 1", nsr - b); end
        checks++; if (spi_en !== 1'b1) begin errors++; $display("FAIL soft_reset_en got %b want 1", spi_en); end
        send_frame(8'h0C, 8'h00, 8'h00, 1);
    endtask

    task automatic test_payload();
        int b;
        b = nv;
        send_frame(8'h80, 8'hA5, 8'h3C, 3);
        checks++; if (nv - b !== 2) begin errors++; $display("FAIL payload_count got %0d want 2", nv - b); end
        checks++; if (v_data[b] !== 8'hA5 || v_data[b+1] !== 8'h3C) begin errors++; $display("FAIL payload_data got %h,%h want a5,3c", v_data[b], v_data[b+1]); end
        checks++; if (v_first[b] !== 1'b1 || v_first[b+1] !== 1'b0) begin errors++; $display("FAIL payload_first got %b,%b want 1,0", v_first[b], v_first[b+1]); end
        checks++; if (v_tgt[b] !== 2'b10 || v_tgt[b+1] !== 2'b10) begin errors++; $display("FAIL payload_target got %b,%b want 10,10", v_tgt[b], v_tgt[b+1]); end
        checks++; if (rx_data !== 8'h3C || rx_target !== 2'b10) begin errors++; $display("FAIL payload_hold got %h/%b want 3c/10", rx_data, rx_target); end
    endtask

    task automatic test_readback();
        int b;
        tx_tbl[0] = 8'h00; tx_tbl[1] = 8'h5A; tx_tbl[2] = 8'hC3; tx_tbl[3] = 8'h00;
        b = nv;
        send_frame(8'h40, 8'h11, 8'h22, 3);
        checks++; if (rd[0] !== 8'h00) begin errors++; $display("FAIL miso_byte1 got %h want 00", rd[0]); end
        checks++; if (rd[1] !== 8'h5A) begin errors++; $display("FAIL miso_byte2 got %h want 5a", rd[1]); end
        checks++; if (rd[2] !== 8'hC3) begin errors++; $display("FAIL miso_byte3 got %h want c3", rd[2]); end
        checks++; if (nv - b !== 2 || v_data[b] !== 8'h11 || v_data[b+1] !== 8'h22 || v_tgt[b] !== 2'b01) begin errors++; $display("FAIL readback_rx got n=%0d %h,%h tgt %b want n=2 11,22 tgt 01", nv - b, v_data[b], v_data[b+1], v_tgt[b]); end
        checks++; if (tx_cnt - tx_base !== 4) begin errors++; $display("FAIL tx_req_count got %0d want 4", tx_cnt - tx_base); end
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL miso_idle got %b want 0", MISO); end
    endtask

    task automatic test_abort();
        int b;
        for (int i = 0; i < 4; i++) tx_tbl[i] = 8'h00;
        b = nv;
        frame_start();
        spi_bits(8'hC0, 8, rd[0]);
        spi_bits(8'hF0, 4, rd[1]);
        frame_stop();
        checks++; if (nv - b !== 0) begin errors++; $display("FAIL abort_no_valid got %0d want 0", nv - b); end
        checks++; if (dut.bit_cnt !== 3'd0) begin errors++; $display("FAIL abort_counter got %0d want 0", dut.bit_cnt); end
        b = nv;
        send_frame(8'hC0, 8'h77, 8'h00, 2);
        checks++; if (nv - b !== 1 || v_data[b] !== 8'h77 || v_first[b] !== 1'b1 || v_tgt[b] !== 2'b11) begin errors++; $display("FAIL abort_next got n=%0d %h first %b tgt %b want n=1 77 first 1 tgt 11", nv - b, v_data[b], v_first[b], v_tgt[b]); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) tx_tbl[i] = 8'hFF;
        send_frame(8'h0E, 8'h00, 8'h00, 1);
        frame_start();
        spi_bits(8'h80, 8, rd[0]);
        spi_bits(8'h99, 8, rd[1]);
        spi_bits(8'h50, 4, rd[2]);
        #40;
        checks++; if (MISO !== 1'b1 || rx_data !== 8'h99 || spi_en !== 1'b1) begin errors++; $display("FAIL pre_reset got miso %b data %h en %b want 1 99 1", MISO, rx_data, spi_en); end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({spi_en, MISO, frame_active, rx_valid, rx_first, tx_req, soft_reset} !== 7'b0) begin errors++; $display("FAIL async_reset_flags got %b want 0000000", {spi_en, MISO, frame_active, rx_valid, rx_first, tx_req, soft_reset}); end
        checks++; if (rx_data !== 8'h00 || rx_target !== 2'b00) begin errors++; $display("FAIL async_reset_rx got %h/%b want 00/00", rx_data, rx_target); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL async_reset_state got %0d want IDLE", dut.state); end
        chip_select_n = 1'b1;
        MOSI = 1'b0;
        #50;
        @(negedge clk);
        reset_n = 1'b1;
        #100;
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL post_reset_idle got %b want 0", frame_active); end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_soft_reset();
        test_payload();
        test_readback();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
